// File: rtl/axicb_wr_arb_pkg.sv
// Shared types and helpers for the write-path burst arbiter.
// State encoding and index to one-hot conversion.
package axicb_wr_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } aw_state_e;

  function automatic logic [MAX_REQ-1:0] idx2onehot(
    input logic [2:0] idx
  );
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/axicb_wr_order_fifo.sv
// Order FIFO of granted master indices.
// Head entry selects which master owns the W channel.
module axicb_wr_order_fifo
  import axicb_wr_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Pointers wrap naturally; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axicb_wr_burst_arbiter.sv
// Round-robin AW arbiter with in-order W burst routing.
// Drives mux selects and handshakes for one slave port.
module axicb_wr_burst_arbiter
  import axicb_wr_arb_pkg::*;
#(
  parameter int REQ_NB     = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int IW = $clog2(REQ_NB),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic [REQ_NB-1:0] awvalid_i,
  output logic [REQ_NB-1:0] awready_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [REQ_NB-1:0] aw_sel,
  input  logic [REQ_NB-1:0] wvalid_i,
  input  logic [REQ_NB-1:0] wlast_i,
  output logic [REQ_NB-1:0] wready_o,
  output logic              wvalid_o,
  output logic              wlast_o,
  input  logic              wready_i,
  output logic [REQ_NB-1:0] w_sel,
  output logic              busy
);

  aw_state_e         r_state;
  aw_state_e         w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_win;
  logic [REQ_NB-1:0] r_sel;

  logic              w_found;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_idx;
  logic [REQ_NB-1:0] w_win_oh;
  logic [IW-1:0]     w_ptr_nxt;
  logic              w_grant;
  logic              w_push;
  logic              w_pop;
  logic              w_awvalid;
  logic [REQ_NB-1:0] w_awready;

  logic [IW-1:0]     w_head;
  logic [REQ_NB-1:0] w_head_oh;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;

  // First requester at or after r_ptr, scanning with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % REQ_NB);
      if (!w_found && awvalid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_oh  = REQ_NB'(idx2onehot(3'(w_win)));
  assign w_ptr_nxt = (r_win == IW'(REQ_NB - 1)) ?
                     '0 : r_win + IW'(1);

  // AW state register.
  always_ff @(posedge aclk) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // AW next state and handshake steering.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_push      = 1'b0;
    w_awvalid   = 1'b0;
    w_awready   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found && !w_full) begin
          w_grant     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_awvalid        = awvalid_i[r_win];
        w_awready[r_win] = awready_i;
        w_push           = w_awvalid & awready_i;
        if (w_push) w_state_nxt = IDLE;
      end
    endcase
  end

  // Winner capture on grant, pointer advance on handshake.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_sel <= '0;
      r_win <= '0;
      r_ptr <= '0;
    end else if (w_grant) begin
      r_sel <= w_win_oh;
      r_win <= w_win;
    end else if (w_push) begin
      r_sel <= '0;
      r_ptr <= w_ptr_nxt;
    end
  end

  assign aw_sel    = r_sel;
  assign awvalid_o = w_awvalid;
  assign awready_o = w_awready;

  axicb_wr_order_fifo #(
    .WIDTH (IW),
    .DEPTH (FIFO_DEPTH)
  ) u_order_fifo (
    .clk     (aclk),
    .srst    (srst),
    .i_push  (w_push),
    .i_din   (r_win),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_oh = REQ_NB'(idx2onehot(3'(w_head)));

  // W channel follows the oldest outstanding burst.
  always_comb begin
    w_sel    = '0;
    wvalid_o = 1'b0;
    wlast_o  = 1'b0;
    wready_o = '0;
    if (!w_empty) begin
      w_sel    = w_head_oh;
      wvalid_o = wvalid_i[w_head];
      wlast_o  = wlast_i[w_head];
      wready_o = w_head_oh & {REQ_NB{wready_i}};
    end
  end

  assign w_pop = wvalid_o & wready_i & wlast_o;
  assign busy  = (r_state == GRANT) | (w_count != '0);

endmodule
